mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported, randomly stalling 32-bit/64 KB memory between the core's instruction-fetch port (read-only) and data port (read/write). It chooses a winner, locks the memory to that port until the memory asserts `ready`, returns data, `ack` and `err` to the owner, and keeps saturating per-port stall counters for performance analysis. It sits between the pipeline's fetch/memory stages and the memory model.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/sat_counter.sv | 25 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter slice.
//   - arb_state_e : arbiter FSM states
//   - PORT_I/PORT_D : port identifiers (also the encoding of the round-robin 'last' bit)
//   - AW_DEF/DW_DEF/CW_DEF : default address, data and stall-counter widths
//   - rr_pick : round-robin winner selection between the two ports
package mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN_I,
    ARB_OWN_D
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Winner among the current requesters. On a tie the port that was not
  // served last wins. With no requester the result is meaningless; callers
  // qualify it with (if_req | d_req).
  function automatic logic rr_pick(input logic if_req, input logic d_req,
                                   input logic last);
    logic win;
    if (if_req && d_req) win = ~last;
    else if (d_req)      win = PORT_D;
    else                 win = PORT_I;
    return win;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: CW-bit saturating up-counter with synchronous clear.
//   clk   : clock
//   clr   : synchronous clear (wins over inc)
//   inc   : add one this cycle unless already at all-ones
//   count : current value
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, randomly stalling memory between the
// instruction-fetch port (read-only) and the data port (read/write).
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr                   : fetch request (held until if_ack)
//   if_ack/if_rdata/if_err           : fetch completion, data, misalignment
//   d_req/d_wr/d_addr/d_wdata        : data request (held until d_ack)
//   d_ack/d_rdata/d_err              : data completion, load data, misalignment
//   m_enable/m_wr/m_addr/m_wdata     : memory command (all zero when idle)
//   m_rdata/m_ready/m_err            : memory response
//   if_stall_cnt/d_stall_cnt         : saturating count of waiting cycles
// A winner is picked combinationally in IDLE; if the memory is not ready in
// that cycle the winner keeps the memory (OWN_I/OWN_D) until m_ready.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_enable,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  input  logic          m_err,
  output logic [CW-1:0] if_stall_cnt,
  output logic [CW-1:0] d_stall_cnt
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       grant_i, grant_d;
  logic       win;
  logic [CW-1:0] if_cnt, d_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= PORT_D;   // fetch wins the first tie
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    win     = rr_pick(if_req, d_req, last_q);

    unique case (state_q)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          grant_i = (win == PORT_I);
          grant_d = (win == PORT_D);
          if (m_ready) last_d  = win;
          else         state_d = (win == PORT_I) ? ARB_OWN_I : ARB_OWN_D;
        end
      end
      // The owner keeps the memory even if it drops req; the other port
      // is ignored until m_ready.
      ARB_OWN_I: begin
        grant_i = 1'b1;
        if (m_ready) begin
          last_d  = PORT_I;
          state_d = ARB_IDLE;
        end
      end
      ARB_OWN_D: begin
        grant_d = 1'b1;
        if (m_ready) begin
          last_d  = PORT_D;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Nothing reaches the memory while reset is asserted, so a store held
    // across reset can never be written.
    if (rst) begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Memory command mux: zeros when nothing is granted.
  always_comb begin
    m_enable = grant_i | grant_d;
    m_wr     = grant_d & d_wr;
    m_addr   = '0;
    m_wdata  = '0;
    if (grant_i) begin
      m_addr = if_addr;
    end else if (grant_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign if_ack   = grant_i & m_ready;
  assign d_ack    = grant_d & m_ready;
  assign if_rdata = if_ack ? m_rdata : '0;
  assign d_rdata  = d_ack  ? m_rdata : '0;
  assign if_err   = if_ack & m_err;
  assign d_err    = d_ack  & m_err;

  sat_counter #(.CW(CW)) u_if_stall (
    .clk   (clk),
    .clr   (rst),
    .inc   (if_req & ~if_ack),
    .count (if_cnt)
  );

  sat_counter #(.CW(CW)) u_d_stall (
    .clk   (clk),
    .clr   (rst),
    .inc   (d_req & ~d_ack),
    .count (d_cnt)
  );

  // Counters read as zero during the reset cycle itself, before the clear lands.
  assign if_stall_cnt = rst ? '0 : if_cnt;
  assign d_stall_cnt  = rst ? '0 : d_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// word-addressed memory model (combinational read, write at the clock edge
// ending a ready, aligned, enabled write; misaligned accesses flag m_err).
// A second instance with a 3-bit counter width exercises saturation.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          m_enable;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic          m_err;
  logic [CW-1:0] if_stall_cnt;
  logic [CW-1:0] d_stall_cnt;

  // Saturation instance signals
  logic          s_d_req;
  logic          s_if_ack, s_if_err, s_d_ack, s_d_err;
  logic [DW-1:0] s_if_rdata, s_d_rdata, s_m_wdata;
  logic          s_m_enable, s_m_wr;
  logic [AW-1:0] s_m_addr;
  logic [2:0]    s_if_cnt, s_d_cnt;

  logic [DW-1:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ack       (if_ack),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .m_enable     (m_enable),
    .m_wr         (m_wr),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_ready      (m_ready),
    .m_err        (m_err),
    .if_stall_cnt (if_stall_cnt),
    .d_stall_cnt  (d_stall_cnt)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .CW(3)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .if_req       (1'b0),
    .if_addr      ('0),
    .if_ack       (s_if_ack),
    .if_rdata     (s_if_rdata),
    .if_err       (s_if_err),
    .d_req        (s_d_req),
    .d_wr         (1'b0),
    .d_addr       (16'h0040),
    .d_wdata      ('0),
    .d_ack        (s_d_ack),
    .d_rdata      (s_d_rdata),
    .d_err        (s_d_err),
    .m_enable     (s_m_enable),
    .m_wr         (s_m_wr),
    .m_addr       (s_m_addr),
    .m_wdata      (s_m_wdata),
    .m_rdata      ('0),
    .m_ready      (1'b0),
    .m_err        (1'b0),
    .if_stall_cnt (s_if_cnt),
    .d_stall_cnt  (s_d_cnt)
  );

  // Memory model
  assign m_err   = m_enable && (m_addr[1:0] != 2'b00);
  assign m_rdata = m_enable ? mem[m_addr[7:2]] : '0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hCAFE_0010;   // 0x0010
    mem[8] = 32'h1234_5678;   // 0x0020
    forever begin
      @(posedge clk);
      if (m_enable && m_wr && m_ready && !m_err) mem[m_addr[7:2]] = m_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    s_d_req = 1'b0;
    idle_inputs();
    rst = 1'b1;
    #2;

    // Reset: requests and a held store present, everything must stay quiet.
    if_req  = 1'b1; if_addr = 16'h0010;
    d_req   = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 32'hDEAD_BEEF;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("rst_m_enable", 64'(m_enable), 64'd0);
      check("rst_if_ack",   64'(if_ack),   64'd0);
      check("rst_d_ack",    64'(d_ack),    64'd0);
      tick();
    end
    check("rst_no_write", 64'(mem[8]), 64'h1234_5678);
    idle_inputs();
    rst = 1'b0;
    settle();
    check("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
    check("rst_if_cnt", 64'(if_stall_cnt), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);

    // Fetch only, memory ready immediately.
    tick();
    if_req = 1'b1; if_addr = 16'h0010; m_ready = 1'b1;
    settle();
    check("f_ack",   64'(if_ack),   64'd1);
    check("f_rdata", 64'(if_rdata), 64'hCAFE_0010);
    check("f_err",   64'(if_err),   64'd0);
    check("f_maddr", 64'(m_addr),   64'h0010);
    check("f_dack",  64'(d_ack),    64'd0);
    tick();
    idle_inputs();
    settle();
    check("f_cnt",   64'(if_stall_cnt), 64'd0);
    check("f_state", 64'(dut.state_q),  64'(ARB_IDLE));

    // Load with three not-ready cycles.
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; m_ready = 1'b0;
    settle();
    check("ld_c1_ack",  64'(d_ack),  64'd0);
    check("ld_c1_addr", 64'(m_addr), 64'h0020);
    check("ld_c1_en",   64'(m_enable), 64'd1);
    for (int k = 2; k <= 3; k++) begin
      tick();
      settle();
      check("ld_own_state", 64'(dut.state_q), 64'(ARB_OWN_D));
      check("ld_own_ack",   64'(d_ack),       64'd0);
      check("ld_own_addr",  64'(m_addr),      64'h0020);
    end
    tick();
    m_ready = 1'b1;
    settle();
    check("ld_c4_state", 64'(dut.state_q), 64'(ARB_OWN_D));
    check("ld_c4_ack",   64'(d_ack),       64'd1);
    check("ld_c4_rdata", 64'(d_rdata),     64'h1234_5678);
    check("ld_c4_addr",  64'(m_addr),      64'h0020);
    check("ld_c4_cnt",   64'(d_stall_cnt), 64'd3);
    tick();
    d_req = 1'b0; m_ready = 1'b0;
    settle();
    check("ld_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    check("ld_cnt_hold", 64'(d_stall_cnt), 64'd3);

    // Both request continuously after reset: I, D, I, D with no gaps.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0010;
    d_req  = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_en",    64'(m_enable), 64'd1);
      check("rr_if",    64'(if_ack),   64'((k % 2) == 0));
      check("rr_d",     64'(d_ack),    64'((k % 2) == 1));
      check("rr_addr",  64'(m_addr),   ((k % 2) == 0) ? 64'h0010 : 64'h0020);
      tick();
    end
    idle_inputs();
    settle();
    check("rr_if_cnt", 64'(if_stall_cnt), 64'd2);
    check("rr_d_cnt",  64'(d_stall_cnt),  64'd2);

    // Fetch arrives while data owns the memory.
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; m_ready = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 16'h0010;
    settle();
    check("wt_state", 64'(dut.state_q), 64'(ARB_OWN_D));
    check("wt_ifack", 64'(if_ack),      64'd0);
    check("wt_addr",  64'(m_addr),      64'h0020);
    tick();
    tick();
    m_ready = 1'b1;
    settle();
    check("wt_dack",   64'(d_ack),  64'd1);
    check("wt_ifack2", 64'(if_ack), 64'd0);
    tick();
    d_req = 1'b0;
    settle();
    check("wt_if_grant", 64'(if_ack),       64'd1);
    check("wt_if_rdata", 64'(if_rdata),     64'hCAFE_0010);
    check("wt_if_cnt",   64'(if_stall_cnt), 64'd3);
    tick();
    idle_inputs();

    // Misaligned store is acked with err and leaves memory untouched.
    do_reset();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0021; d_wdata = 32'hDEAD_BEEF; m_ready = 1'b1;
    settle();
    check("ma_ack", 64'(d_ack), 64'd1);
    check("ma_err", 64'(d_err), 64'd1);
    check("ma_mwr", 64'(m_wr),  64'd1);
    tick();
    d_wr = 1'b0; d_addr = 16'h0020; d_wdata = '0;
    settle();
    check("ma_rd_ack",   64'(d_ack),   64'd1);
    check("ma_rd_err",   64'(d_err),   64'd0);
    check("ma_rd_rdata", 64'(d_rdata), 64'h1234_5678);
    tick();
    // Aligned store followed by a read-back.
    d_wr = 1'b1; d_addr = 16'h0024; d_wdata = 32'hA5A5_5A5A;
    settle();
    check("st_ack",   64'(d_ack),   64'd1);
    check("st_wdata", 64'(m_wdata), 64'hA5A5_5A5A);
    tick();
    d_wr = 1'b0; d_wdata = '0;
    settle();
    check("st_rdback", 64'(d_rdata), 64'hA5A5_5A5A);
    tick();
    idle_inputs();

    // Reset in the middle of a fetch ownership.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0010; m_ready = 1'b0;
    tick();
    settle();
    check("ro_state", 64'(dut.state_q), 64'(ARB_OWN_I));
    rst = 1'b1; m_ready = 1'b1;
    settle();
    check("ro_ack", 64'(if_ack),   64'd0);
    check("ro_en",  64'(m_enable), 64'd0);
    check("ro_cnt", 64'(if_stall_cnt), 64'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    check("ro_state2", 64'(dut.state_q),  64'(ARB_IDLE));
    check("ro_if_cnt", 64'(if_stall_cnt), 64'd0);
    check("ro_d_cnt",  64'(d_stall_cnt),  64'd0);
    check("ro_en2",    64'(m_enable),     64'd0);

    // Saturation on the 3-bit instance: 10 stalled cycles stop at 7.
    s_d_req = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    settle();
    check("sat_6", 64'(s_d_cnt), 64'd6);
    for (int k = 0; k < 4; k++) tick();
    settle();
    check("sat_max", 64'(s_d_cnt),  64'd7);
    check("sat_if",  64'(s_if_cnt), 64'd0);
    s_d_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
